mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single cache/SRAM memory port between the IF stage (read-only) and the MEM stage (read/write). It sits between the pipeline stages and the cache controller, and holds ownership for the full length of a frozen transaction. It returns per-requester freeze and read data, and applies MEM-first priority with a bounded-wait guarantee for IF.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/arb_wait_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM state encodings and owner select codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OWN_MEM = 2'd1,
        ARB_OWN_IF  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_IF   = 2'd2
    } owner_sel_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles IF has been denied the memory port.
module arb_wait_counter #(
    parameter int unsigned MAX_WAIT = 4,
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    assign at_limit = (count == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache/SRAM port between IF (read-only) and MEM (read/write), MEM-first with bounded IF wait.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_freeze,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_r_en,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_freeze,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [DATA_W-1:0] dn_wdata,
    output logic              dn_r_en,
    output logic              dn_w_en,
    input  logic [DATA_W-1:0] dn_rdata,
    input  logic              dn_freeze
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    owner_sel_e       owner;
    logic             mem_req;
    logic             if_req;
    logic             wait_inc;
    logic             wait_clr;
    logic             wait_limit;
    logic [CNT_W-1:0] wait_cnt;

    assign mem_req  = mem_r_en | mem_w_en;
    assign if_req   = if_r_en;
    assign wait_inc = if_req && (owner != SEL_IF);
    assign wait_clr = (owner == SEL_IF);

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (wait_inc),
        .clr      (wait_clr),
        .count    (wait_cnt),
        .at_limit (wait_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner selection, downstream mux, freeze/rdata steering; everything forced to 0 during reset.
    always_comb begin
        owner      = SEL_NONE;
        state_nxt  = ARB_IDLE;
        dn_addr    = '0;
        dn_wdata   = '0;
        dn_r_en    = 1'b0;
        dn_w_en    = 1'b0;
        mem_rdata  = '0;
        if_rdata   = '0;
        mem_freeze = mem_req;
        if_freeze  = if_req;

        unique case (state)
            ARB_IDLE: begin
                if (mem_req && if_req) owner = wait_limit ? SEL_IF : SEL_MEM;
                else if (mem_req)      owner = SEL_MEM;
                else if (if_req)       owner = SEL_IF;
            end
            ARB_OWN_MEM: if (mem_req) owner = SEL_MEM;
            ARB_OWN_IF:  if (if_req)  owner = SEL_IF;
            default:     owner = SEL_NONE;
        endcase

        if (owner == SEL_MEM) begin
            dn_addr    = mem_addr;
            dn_wdata   = mem_wdata;
            dn_w_en    = mem_w_en;
            dn_r_en    = mem_r_en && !mem_w_en;
            mem_freeze = dn_freeze;
            if (dn_freeze) state_nxt = ARB_OWN_MEM;
            else if (!mem_w_en) mem_rdata = dn_rdata;
        end else if (owner == SEL_IF) begin
            dn_addr   = if_addr;
            dn_r_en   = 1'b1;
            if_freeze = dn_freeze;
            if (dn_freeze) state_nxt = ARB_OWN_IF;
            else if_rdata = dn_rdata;
        end

        if (rst) begin
            dn_addr    = '0;
            dn_wdata   = '0;
            dn_r_en    = 1'b0;
            dn_w_en    = 1'b0;
            mem_rdata  = '0;
            if_rdata   = '0;
            mem_freeze = 1'b0;
            if_freeze  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_rdata;
    logic        mem_freeze;
    logic [17:0] if_addr;
    logic        if_r_en;
    logic [31:0] if_rdata;
    logic        if_freeze;
    logic [17:0] dn_addr;
    logic [31:0] dn_wdata;
    logic        dn_r_en;
    logic        dn_w_en;
    logic [31:0] dn_rdata;
    logic        dn_freeze;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W   (18),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_rdata  (mem_rdata),
        .mem_freeze (mem_freeze),
        .if_addr    (if_addr),
        .if_r_en    (if_r_en),
        .if_rdata   (if_rdata),
        .if_freeze  (if_freeze),
        .dn_addr    (dn_addr),
        .dn_wdata   (dn_wdata),
        .dn_r_en    (dn_r_en),
        .dn_w_en    (dn_w_en),
        .dn_rdata   (dn_rdata),
        .dn_freeze  (dn_freeze)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_addr = '0; mem_wdata = '0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        if_addr = '0; if_r_en = 1'b0; dn_rdata = '0; dn_freeze = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_addr = 18'h00123; mem_wdata = 32'h11111111; mem_r_en = 1'b1;
        if_addr = 18'h00456; if_r_en = 1'b1; dn_rdata = 32'hCAFEF00D;
        #12;
        checks++; if (dn_r_en !== 1'b0) begin errors++; $display("FAIL reset_dn_r_en got %b exp 0", dn_r_en); end
        checks++; if (dn_w_en !== 1'b0) begin errors++; $display("FAIL reset_dn_w_en got %b exp 0", dn_w_en); end
        checks++; if (dn_addr !== 18'h0) begin errors++; $display("FAIL reset_dn_addr got %h exp 0", dn_addr); end
        checks++; if (dn_wdata !== 32'h0) begin errors++; $display("FAIL reset_dn_wdata got %h exp 0", dn_wdata); end
        checks++; if (mem_freeze !== 1'b0 || if_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze got %b%b exp 00", mem_freeze, if_freeze); end
        checks++; if (mem_rdata !== 32'h0 || if_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", mem_rdata, if_rdata); end
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_if_hit();
        if_addr = 18'h00010; if_r_en = 1'b1; dn_rdata = 32'hDEADBEEF; dn_freeze = 1'b0;
        #1;
        checks++; if (dn_r_en !== 1'b1 || dn_w_en !== 1'b0) begin errors++; $display("FAIL ifhit_en got r%b w%b exp r1 w0", dn_r_en, dn_w_en); end
        checks++; if (dn_addr !== 18'h00010) begin errors++; $display("FAIL ifhit_addr got %h exp 00010", dn_addr); end
        checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifhit_rdata got %h exp deadbeef", if_rdata); end
        checks++; if (if_freeze !== 1'b0 || mem_freeze !== 1'b0) begin errors++; $display("FAIL ifhit_freeze got if%b mem%b exp 0 0", if_freeze, mem_freeze); end
        tick();
        checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL ifhit_state got %0d exp 0", dut.state); end
        idle_inputs();
        #1;
        checks++; if (dn_r_en !== 1'b0 || dn_addr !== 18'h0) begin errors++; $display("FAIL ifhit_after got r%b addr %h exp 0 0", dn_r_en, dn_addr); end
        tick();
    endtask

    task automatic test_miss_both();
        mem_addr = 18'h00AAA; mem_r_en = 1'b1; if_addr = 18'h00BBB; if_r_en = 1'b1;
        dn_rdata = 32'h12345678;
        for (int c = 1; c <= 5; c++) begin
            dn_freeze = (c <= 3);
            #1;
            if (c <= 4) begin
                checks++; if (dn_addr !== 18'h00AAA) begin errors++; $display("FAIL miss_addr c%0d got %h exp 00aaa", c, dn_addr); end
                checks++; if (if_freeze !== 1'b1) begin errors++; $display("FAIL miss_if_freeze c%0d got %b exp 1", c, if_freeze); end
                checks++; if (mem_freeze !== (c <= 3)) begin errors++; $display("FAIL miss_mem_freeze c%0d got %b exp %b", c, mem_freeze, c <= 3); end
                checks++; if (mem_rdata !== ((c == 4) ? 32'h12345678 : 32'h0)) begin errors++; $display("FAIL miss_mem_rdata c%0d got %h", c, mem_rdata); end
            end else begin
                checks++; if (dn_addr !== 18'h00BBB) begin errors++; $display("FAIL miss_if_grant got %h exp 00bbb", dn_addr); end
                checks++; if (if_rdata !== 32'h12345678 || mem_freeze !== 1'b1) begin errors++; $display("FAIL miss_if_done got %h fz%b exp 12345678 fz1", if_rdata, mem_freeze); end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        mem_addr = 18'h00100; mem_r_en = 1'b1; if_addr = 18'h00200; if_r_en = 1'b1;
        dn_freeze = 1'b0; dn_rdata = 32'h0000BEEF;
        for (int c = 1; c <= 6; c++) begin
            #1;
            checks++; if (dn_addr !== ((c == 5) ? 18'h00200 : 18'h00100)) begin errors++; $display("FAIL starve_addr c%0d got %h", c, dn_addr); end
            checks++; if (if_freeze !== (c != 5) || mem_freeze !== (c == 5)) begin errors++; $display("FAIL starve_freeze c%0d got if%b mem%b", c, if_freeze, mem_freeze); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        if_addr = 18'h00040; if_r_en = 1'b1; dn_freeze = 1'b1; dn_rdata = 32'hA5A5A5A5;
        #1;
        checks++; if (dn_addr !== 18'h00040 || if_freeze !== 1'b1) begin errors++; $display("FAIL lock_c1 got %h fz%b exp 00040 fz1", dn_addr, if_freeze); end
        tick();
        mem_addr = 18'h00077; mem_wdata = 32'h55AA55AA; mem_w_en = 1'b1;
        #1;
        checks++; if (dn_w_en !== 1'b0 || dn_r_en !== 1'b1) begin errors++; $display("FAIL lock_en got w%b r%b exp w0 r1", dn_w_en, dn_r_en); end
        checks++; if (dn_addr !== 18'h00040 || mem_freeze !== 1'b1) begin errors++; $display("FAIL lock_hold got %h fz%b exp 00040 fz1", dn_addr, mem_freeze); end
        tick();
        dn_freeze = 1'b0;
        #1;
        checks++; if (if_rdata !== 32'hA5A5A5A5 || mem_freeze !== 1'b1 || dn_w_en !== 1'b0) begin errors++; $display("FAIL lock_done got %h fz%b w%b", if_rdata, mem_freeze, dn_w_en); end
        tick();
        if_r_en = 1'b0; mem_r_en = 1'b1;
        #1;
        checks++; if (dn_w_en !== 1'b1 || dn_r_en !== 1'b0) begin errors++; $display("FAIL write_en got w%b r%b exp w1 r0", dn_w_en, dn_r_en); end
        checks++; if (dn_wdata !== 32'h55AA55AA || dn_addr !== 18'h00077) begin errors++; $display("FAIL write_data got %h @%h", dn_wdata, dn_addr); end
        checks++; if (mem_rdata !== 32'h0 || mem_freeze !== 1'b0) begin errors++; $display("FAIL write_done got %h fz%b exp 0 fz0", mem_rdata, mem_freeze); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        mem_addr = 18'h00300; mem_r_en = 1'b1; dn_freeze = 1'b1; dn_rdata = 32'h0BADF00D;
        tick();
        mem_r_en = 1'b0; dn_freeze = 1'b0;
        #1;
        checks++; if (dn_r_en !== 1'b0 || dn_addr !== 18'h0) begin errors++; $display("FAIL flush_en got r%b %h exp 0", dn_r_en, dn_addr); end
        checks++; if (mem_rdata !== 32'h0 || mem_freeze !== 1'b0) begin errors++; $display("FAIL flush_rdata got %h fz%b exp 0 fz0", mem_rdata, mem_freeze); end
        tick();
        checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL flush_state got %0d exp 0", dut.state); end
        if_addr = 18'h00050; if_r_en = 1'b1;
        #1;
        checks++; if (dn_addr !== 18'h00050 || if_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL flush_next got %h %h", dn_addr, if_rdata); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        mem_addr = 18'h00300; mem_r_en = 1'b1; if_addr = 18'h00400; if_r_en = 1'b1;
        dn_freeze = 1'b1; dn_rdata = 32'h77777777;
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1; dn_freeze = 1'b0;
        #1;
        checks++; if (dn_r_en !== 1'b0 || dn_addr !== 18'h0) begin errors++; $display("FAIL rstmid_dn got r%b %h exp 0", dn_r_en, dn_addr); end
        checks++; if (mem_freeze !== 1'b0 || if_freeze !== 1'b0 || mem_rdata !== 32'h0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_out got fz%b%b %h %h", mem_freeze, if_freeze, mem_rdata, if_rdata); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL rstmid_state got %0d exp 0", dut.state); end
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++; if (dn_addr !== ((c == 5) ? 18'h00400 : 18'h00300)) begin errors++; $display("FAIL rstmid_arb c%0d got %h", c, dn_addr); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_if_hit();
        test_miss_both();
        test_starvation();
        test_lock();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
